fix_session_scheduler: RTL and testbench
========================================

// Module: fix_session_scheduler
// PURPOSE
// Session-level controller in front of the FIX message creator. Decides which admin message
// (logon / heartbeat / logout) is built next, issues its start, owns MsgSeqNum and the
// heartbeat-interval timer, and supervises completion with a watchdog.
// PARAMETERS
// SEQ_WIDTH      32     width of MsgSeqNum counter / msg_seq_num_o
// HB_WIDTH       32     width of heartbeat interval (clock cycles)
// TIMEOUT_CYCLES 4096   max cycles from start_o to msg_creation_done_i before abort
// PORTS
// clk                  in   1          clock
// rst                  in   1          reset
// logon_req_i          in   1          request to open session (pulse or level)
// logout_req_i         in   1          request to close session (pulse or level)
// hb_interval_i        in   HB_WIDTH   heartbeat period in cycles; 0 = heartbeats disabled
// msg_creation_done_i  in   1          creator finished current message (1-cycle pulse)
// start_o              out  1          1-cycle pulse: begin building message_type_o
// message_type_o       out  4          0001 logon, 0010 heartbeat, 0100 logout, 0000 none
// msg_seq_num_o        out  SEQ_WIDTH  MsgSeqNum for the message in flight / next message
// busy_o               out  1          message in flight (start issued, done not yet seen)
// session_up_o         out  1          logon completed and logout not yet completed
// timeout_err_o        out  1          1-cycle pulse: watchdog expired, message aborted
// BEHAVIOUR
// - Reset: reset rst, synchronous, active-high; clock clk. All outputs registered. Reset
//   values: start_o=0, message_type_o=0000, msg_seq_num_o=1, busy_o=0, session_up_o=0,
//   timeout_err_o=0; state=DOWN; pending flags, hb timer, watchdog cleared. Reset
//   mid-message abandons it silently (no timeout_err_o).
// - States: DOWN, LOGON, ACTIVE, HB, LOGOUT. LOGON/HB/LOGOUT = in flight (busy_o=1).
// - Requests latched into pend_logon/pend_logout on any clock with input high; cleared when
//   serviced. logon_req_i ignored unless state=DOWN. logout_req_i ignored in DOWN.
// - Issue: start_o pulses in the cycle immediately following the edge where the
//   transition into an in-flight state is taken; message_type_o is set in that same cycle
//   and held until the cycle after done. Latency: request high at edge k -> start_o high
//   in cycle k+1 when idle.
// - DOWN: pend_logon -> LOGON; sample hb_interval_i into hb_int_r.
// - ACTIVE: priority pend_logout > heartbeat due. hb_cnt clears on entry to ACTIVE, counts
//   +1/cycle; due when hb_int_r!=0 and hb_cnt==hb_int_r-1 -> HB. hb_cnt frozen while in
//   flight.
// - On msg_creation_done_i in flight: msg_seq_num_o increments next cycle; LOGON ->
//   ACTIVE (session_up_o=1) or, if pend_logout, directly LOGOUT; HB -> ACTIVE or LOGOUT
//   if pend_logout; LOGOUT -> DOWN, session_up_o=0, seq reset to 1, pending flags cleared.
// - msg_creation_done_i outside in-flight states ignored. done coincident with start_o
//   cycle counts as completion.
// - Seq wrap: 2^SEQ_WIDTH-1 increments to 1 (0 never emitted).
// - Watchdog: counts cycles in flight, cleared on every start_o. At TIMEOUT_CYCLES with no
//   done: timeout_err_o pulse, state DOWN, session_up_o=0, seq NOT incremented, pending
//   flags cleared. Done arriving in the same cycle as expiry wins (normal completion).
// - Logout request while LOGON/HB in flight is held and serviced right after done.
// TESTING
// 1 rst; logon_req_i pulse -> next cycle start_o=1, type=0001, seq=1; done -> session_up_o=1,
//   seq=2.
// 2 hb_interval_i=10, session up, idle -> start_o with type=0010 exactly 10 cycles after
//   ACTIVE entry; done -> seq+1, timer restarts, next HB 10 cycles later.
// 3 logout_req_i during HB in flight -> after done, start_o type=0100 next cycle;
//   done -> session_up_o=0, seq=1.
// 4 TIMEOUT_CYCLES=16, logon with done never arriving -> timeout_err_o at cycle 16,
//   state DOWN, seq unchanged (1); done at expiry cycle -> no error.
// 5 SEQ_WIDTH=4, 15 completed messages -> seq sequence ...,14,15,1.
// 6 hb_interval_i=0 -> no heartbeat over 1000 cycles; rst mid-LOGON -> all outputs reset
//   values, no timeout_err_o.

Source files
------------

// File: rtl/fix_session_scheduler.sv
// FIX session controller: sequences logon/heartbeat/logout starts, owns MsgSeqNum,
// the heartbeat timer and a completion watchdog. All outputs registered.
module fix_session_scheduler #(
  parameter int SEQ_WIDTH      = 32,
  parameter int HB_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 logon_req_i,
  input  logic                 logout_req_i,
  input  logic [HB_WIDTH-1:0]  hb_interval_i,
  input  logic                 msg_creation_done_i,
  output logic                 start_o,
  output logic [3:0]           message_type_o,
  output logic [SEQ_WIDTH-1:0] msg_seq_num_o,
  output logic                 busy_o,
  output logic                 session_up_o,
  output logic                 timeout_err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] TYPE_NONE   = 4'b0000;
  localparam logic [3:0] TYPE_LOGON  = 4'b0001;
  localparam logic [3:0] TYPE_HB     = 4'b0010;
  localparam logic [3:0] TYPE_LOGOUT = 4'b0100;

  typedef enum logic [2:0] {DOWN, LOGON, ACTIVE, HB, LOGOUT} state_e;

  state_e               state_q, state_d;
  logic                 pend_logon_q, pend_logon_d;
  logic                 pend_logout_q, pend_logout_d;
  logic [HB_WIDTH-1:0]  hb_int_q, hb_int_d;
  logic [HB_WIDTH-1:0]  hb_cnt_q, hb_cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 start_q, start_d;
  logic [3:0]           type_q, type_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic                 busy_q, busy_d;
  logic                 up_q, up_d;
  logic                 terr_q, terr_d;

  logic in_flight, done_ev, expire, lo_req, hb_due, enter_flight;

  function automatic logic is_flight(state_e s);
    return (s == LOGON) || (s == HB) || (s == LOGOUT);
  endfunction

  assign in_flight    = is_flight(state_q);
  assign done_ev      = in_flight && msg_creation_done_i;
  // Done in the expiry cycle counts as completion, so it suppresses the abort.
  assign expire       = in_flight && !msg_creation_done_i &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign lo_req       = pend_logout_q || logout_req_i;
  assign hb_due       = (hb_int_q != '0) && (hb_cnt_q == hb_int_q - HB_WIDTH'(1));
  assign enter_flight = is_flight(state_d) && (state_d != state_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= DOWN;
      pend_logon_q  <= 1'b0;
      pend_logout_q <= 1'b0;
      hb_int_q      <= '0;
      hb_cnt_q      <= '0;
      wd_q          <= '0;
      start_q       <= 1'b0;
      type_q        <= TYPE_NONE;
      seq_q         <= SEQ_WIDTH'(1);
      busy_q        <= 1'b0;
      up_q          <= 1'b0;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_logon_q  <= pend_logon_d;
      pend_logout_q <= pend_logout_d;
      hb_int_q      <= hb_int_d;
      hb_cnt_q      <= hb_cnt_d;
      wd_q          <= wd_d;
      start_q       <= start_d;
      type_q        <= type_d;
      seq_q         <= seq_d;
      busy_q        <= busy_d;
      up_q          <= up_d;
      terr_q        <= terr_d;
    end
  end

  // Next state plus pending flags, heartbeat timer and watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DOWN:   if (pend_logon_q || logon_req_i) state_d = LOGON;
      ACTIVE: begin
        if (lo_req)      state_d = LOGOUT;
        else if (hb_due) state_d = HB;
      end
      LOGON, HB: begin
        if (done_ev)     state_d = lo_req ? LOGOUT : ACTIVE;
        else if (expire) state_d = DOWN;
      end
      LOGOUT: if (done_ev || expire) state_d = DOWN;
      default: state_d = DOWN;
    endcase

    pend_logon_d = pend_logon_q || (logon_req_i && state_q == DOWN);
    if (state_q != DOWN || state_d != DOWN) pend_logon_d = 1'b0;

    pend_logout_d = pend_logout_q || (logout_req_i && state_q != DOWN);
    if (state_d == DOWN || (state_d == LOGOUT && state_q != LOGOUT)) pend_logout_d = 1'b0;

    hb_int_d = (state_q == DOWN) ? hb_interval_i : hb_int_q;

    hb_cnt_d = hb_cnt_q;
    if (state_d == ACTIVE && state_q != ACTIVE) hb_cnt_d = '0;
    else if (state_q == ACTIVE)                 hb_cnt_d = hb_cnt_q + HB_WIDTH'(1);

    wd_d = '0;
    if (!enter_flight && in_flight) wd_d = wd_q + WD_W'(1);
  end

  // Registered output next-values
  always_comb begin
    start_d = enter_flight;
    busy_d  = is_flight(state_d);
    up_d    = (state_d == ACTIVE) || (state_d == HB) || (state_d == LOGOUT);
    terr_d  = expire;
    unique case (state_d)
      LOGON:   type_d = TYPE_LOGON;
      HB:      type_d = TYPE_HB;
      LOGOUT:  type_d = TYPE_LOGOUT;
      default: type_d = TYPE_NONE;
    endcase
    seq_d = seq_q;
    if (done_ev) begin
      if (state_q == LOGOUT || seq_q == '1) seq_d = SEQ_WIDTH'(1);
      else                                  seq_d = seq_q + SEQ_WIDTH'(1);
    end
  end

  assign start_o        = start_q;
  assign message_type_o = type_q;
  assign msg_seq_num_o  = seq_q;
  assign busy_o         = busy_q;
  assign session_up_o   = up_q;
  assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_fix_session_scheduler.sv
// Directed bench for fix_session_scheduler; every start_o is matched against a
// queue of expected {type, seq} pushed when the triggering stimulus is driven.
module tb_fix_session_scheduler;

  localparam int SW = 4;
  localparam int HW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          logon_req_i, logout_req_i, msg_creation_done_i;
  logic [HW-1:0] hb_interval_i;
  logic          start_o, busy_o, session_up_o, timeout_err_o;
  logic [3:0]    message_type_o;
  logic [SW-1:0] msg_seq_num_o;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  fix_session_scheduler #(.SEQ_WIDTH(SW), .HB_WIDTH(HW), .TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .logon_req_i         (logon_req_i),
    .logout_req_i        (logout_req_i),
    .hb_interval_i       (hb_interval_i),
    .msg_creation_done_i (msg_creation_done_i),
    .start_o             (start_o),
    .message_type_o      (message_type_o),
    .msg_seq_num_o       (msg_seq_num_o),
    .busy_o              (busy_o),
    .session_up_o        (session_up_o),
    .timeout_err_o       (timeout_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    msg_creation_done_i = 1'b1;
    tick();
    msg_creation_done_i = 1'b0;
  endtask

  task automatic wait_start(input int limit, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (start_o) seen = 1'b1;
      else tick();
    end
  endtask

  // Scoreboard monitor: every start pops one expected message.
  always @(negedge clk) begin
    if (!rst && start_o) begin
      if (exp_q.size() == 0) chk("unexpected_start", {message_type_o, msg_seq_num_o}, 32'hFFFF);
      else chk("sb_msg", {message_type_o, msg_seq_num_o}, exp_q.pop_front());
    end
  end

  initial begin
    logic seen, clean;
    int   starts;
    rst = 1'b1; logon_req_i = 0; logout_req_i = 0; msg_creation_done_i = 0;
    hb_interval_i = HW'(10);
    tick(); tick();
    chk("rst_start", start_o, 0);
    chk("rst_type", message_type_o, 0);
    chk("rst_seq", msg_seq_num_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_up", session_up_o, 0);
    chk("rst_terr", timeout_err_o, 0);
    rst = 1'b0;

    // Logon: start the cycle after the request edge
    exp_q.push_back({4'b0001, 4'd1});
    logon_req_i = 1; tick(); logon_req_i = 0;
    chk("logon_start", start_o, 1);
    chk("logon_type", message_type_o, 4'b0001);
    chk("logon_busy", busy_o, 1);
    tick(); pulse_done();
    chk("logon_up", session_up_o, 1);
    chk("logon_seq", msg_seq_num_o, 2);
    chk("logon_type_clr", message_type_o, 0);

    // Heartbeat exactly 10 cycles after ACTIVE entry
    exp_q.push_back({4'b0010, 4'd2});
    clean = 1'b1;
    for (int i = 1; i < 10; i++) begin tick(); if (start_o) clean = 1'b0; end
    chk("hb1_early", clean, 1);
    tick();
    chk("hb1_start", start_o, 1);
    pulse_done();  // done in the start cycle completes the message
    chk("hb1_seq", msg_seq_num_o, 3);
    exp_q.push_back({4'b0010, 4'd3});
    clean = 1'b1;
    for (int i = 1; i < 10; i++) begin tick(); if (start_o) clean = 1'b0; end
    chk("hb2_early", clean, 1);
    tick();
    chk("hb2_start", start_o, 1);

    // Logout requested while the heartbeat is in flight
    exp_q.push_back({4'b0100, 4'd4});
    logout_req_i = 1; tick(); logout_req_i = 0;
    pulse_done();
    chk("logout_start", start_o, 1);
    chk("logout_type", message_type_o, 4'b0100);
    chk("logout_up_held", session_up_o, 1);
    pulse_done();
    chk("logout_up", session_up_o, 0);
    chk("logout_seq", msg_seq_num_o, 1);
    chk("logout_busy", busy_o, 0);

    // Watchdog expiry
    hb_interval_i = '0;
    exp_q.push_back({4'b0001, 4'd1});
    logon_req_i = 1; tick(); logon_req_i = 0;
    clean = 1'b1;
    for (int i = 0; i < TO; i++) begin if (timeout_err_o) clean = 1'b0; tick(); end
    chk("to_early", clean, 1);
    chk("to_err", timeout_err_o, 1);
    chk("to_busy", busy_o, 0);
    chk("to_up", session_up_o, 0);
    chk("to_seq", msg_seq_num_o, 1);
    tick();
    chk("to_pulse", timeout_err_o, 0);

    // Done in the expiry cycle wins
    exp_q.push_back({4'b0001, 4'd1});
    logon_req_i = 1; tick(); logon_req_i = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    pulse_done();
    chk("edge_terr", timeout_err_o, 0);
    chk("edge_up", session_up_o, 1);
    chk("edge_seq", msg_seq_num_o, 2);
    exp_q.push_back({4'b0100, 4'd2});
    logout_req_i = 1; tick(); logout_req_i = 0;
    pulse_done();
    chk("edge_logout_seq", msg_seq_num_o, 1);

    // Sequence wrap 15 -> 1 using short heartbeats
    hb_interval_i = HW'(2);
    exp_q.push_back({4'b0001, 4'd1});
    logon_req_i = 1; tick(); logon_req_i = 0;
    pulse_done();
    for (int k = 2; k <= 15; k++) begin
      exp_q.push_back({4'b0010, 4'(k)});
      wait_start(20, seen);
      chk("wrap_hb_seen", seen, 1);
      pulse_done();
    end
    chk("wrap_seq", msg_seq_num_o, 1);
    exp_q.push_back({4'b0010, 4'd1});
    wait_start(20, seen);
    chk("wrap_hb_after", seen, 1);
    pulse_done();
    exp_q.push_back({4'b0100, 4'd2});
    logout_req_i = 1; tick(); logout_req_i = 0;
    chk("wrap_logout", start_o, 1);
    pulse_done();

    // Heartbeats disabled
    hb_interval_i = '0;
    tick();
    exp_q.push_back({4'b0001, 4'd1});
    logon_req_i = 1; tick(); logon_req_i = 0;
    pulse_done();
    starts = 0;
    for (int i = 0; i < 1000; i++) begin tick(); if (start_o) starts++; end
    chk("nohb_starts", starts, 0);
    exp_q.push_back({4'b0100, 4'd2});
    logout_req_i = 1; tick(); logout_req_i = 0;
    pulse_done();

    // Reset mid-logon
    exp_q.push_back({4'b0001, 4'd1});
    logon_req_i = 1; tick(); logon_req_i = 0;
    tick(); tick(); tick();
    rst = 1'b1; tick();
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_type", message_type_o, 0);
    chk("mid_rst_seq", msg_seq_num_o, 1);
    chk("mid_rst_up", session_up_o, 0);
    chk("mid_rst_start", start_o, 0);
    rst = 1'b0;
    clean = 1'b1;
    for (int i = 0; i < 30; i++) begin tick(); if (timeout_err_o || busy_o) clean = 1'b0; end
    chk("mid_rst_silent", clean, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
